// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file.
package register_file_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int DEFAULT_NREG = 32;

    typedef logic [WORD_SIZE-1:0]  word_t;
    typedef logic [REG_ADDR_W-1:0] regAddr_t;

endpackage

// File: rtl/register_file_pending_counter.sv
// Saturating up/down counter tracking in-flight writers of one register.
// One increment and up to two decrements may land in the same cycle; the
// net delta is applied at once and clamped to [0, 2**CNT_W-1].
module pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    // Three extra bits keep the signed sum exact for any +1/-2 delta.
    localparam int SUM_W = CNT_W + 3;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((2 ** CNT_W) - 1);

    logic signed [SUM_W-1:0] sum;
    logic [CNT_W-1:0]        cntNext;

    // Net delta plus clamping; err flags a clamp happening this cycle.
    always_comb begin
        sum = $signed({3'b000, cnt})
            + $signed({{(CNT_W + 2){1'b0}}, inc})
            - $signed({{(CNT_W + 1){1'b0}}, dec});
        cntNext = sum[CNT_W-1:0];
        err     = 1'b0;
        if (sum[SUM_W-1]) begin
            cntNext = '0;
            err     = 1'b1;
        end else if (sum > SUM_MAX) begin
            cntNext = SUM_MAX[CNT_W-1:0];
            err     = 1'b1;
        end
    end

    // Counter state, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cntNext;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file: one write port from writeback, two
// combinational read ports for decode with write-through, and a
// per-register pending-write scoreboard driving the busy flags.
module register_file
    import register_file_pkg::*;
#(
    parameter int NREG  = DEFAULT_NREG,
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] A1D,
    input  logic [REG_ADDR_W-1:0] A2D,
    output logic [WORD_SIZE-1:0]  RD1D,
    output logic [WORD_SIZE-1:0]  RD2D,
    output logic                  Busy1D,
    output logic                  Busy2D,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] A3W,
    input  logic [WORD_SIZE-1:0]  WD3W,
    input  logic                  IssueD,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  KillE,
    input  logic [REG_ADDR_W-1:0] RdE,
    output logic                  OvfErr
);

    word_t            regFile [NREG];
    logic [CNT_W-1:0] pendCnt [NREG];
    logic [NREG-1:0]  clampErr;

    // Read mux with writeback bypass; x0 always reads zero.
    function automatic word_t readPort(
        input regAddr_t addr,
        input word_t    file [NREG],
        input logic     wrEn,
        input regAddr_t wrAddr,
        input word_t    wrData
    );
        word_t result;
        result = '0;
        if (addr == '0) begin
            result = '0;
        end else if (wrEn && (wrAddr == addr)) begin
            result = wrData;
        end else if (int'(addr) < NREG) begin
            result = file[addr];
        end
        return result;
    endfunction

    // Busy unless the only outstanding writer is completing right now.
    function automatic logic busyPort(
        input regAddr_t         addr,
        input logic [CNT_W-1:0] counts [NREG],
        input logic             wrEn,
        input regAddr_t         wrAddr,
        input logic             inReset
    );
        logic             result;
        logic [CNT_W-1:0] completing;
        result     = 1'b0;
        completing = CNT_W'(wrEn && (wrAddr == addr));
        if (!inReset && (addr != '0) && (int'(addr) < NREG)) begin
            result = (counts[addr] != completing);
        end
        return result;
    endfunction

    // x0 has neither storage nor a scoreboard entry.
    assign regFile[0]  = '0;
    assign pendCnt[0]  = '0;
    assign clampErr[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : gReg
            logic wrHit;
            logic killHit;
            logic issueHit;

            assign wrHit    = RegWriteW && (A3W == REG_ADDR_W'(gi));
            assign killHit  = KillE     && (RdE == REG_ADDR_W'(gi));
            assign issueHit = IssueD    && (RdD == REG_ADDR_W'(gi));

            // Storage for one register; written from writeback only.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regFile[gi] <= '0;
                end else if (wrHit) begin
                    regFile[gi] <= WD3W;
                end
            end

            // dec encodes the number of completing/killed writers (0..2).
            pending_counter #(
                .CNT_W(CNT_W)
            ) uPendCnt (
                .clk (clk),
                .rst (rst),
                .inc (issueHit),
                .dec ({wrHit & killHit, wrHit ^ killHit}),
                .cnt (pendCnt[gi]),
                .err (clampErr[gi])
            );
        end
    endgenerate

    assign RD1D   = readPort(A1D, regFile, RegWriteW, A3W, WD3W);
    assign RD2D   = readPort(A2D, regFile, RegWriteW, A3W, WD3W);
    assign Busy1D = busyPort(A1D, pendCnt, RegWriteW, A3W, !rst);
    assign Busy2D = busyPort(A2D, pendCnt, RegWriteW, A3W, !rst);

    // Sticky overflow/underflow flag across all counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OvfErr <= 1'b0;
        end else if (|clampErr) begin
            OvfErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized traffic, all checked against a behavioural array model.
module tb_register_file;
    import register_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  A1D, A2D, A3W, RdD, RdE;
    logic [31:0] RD1D, RD2D, WD3W;
    logic        Busy1D, Busy2D, RegWriteW, IssueD, KillE, OvfErr;

    int          nVec = 0;
    int          nErr = 0;
    logic [31:0] modelReg [32];
    int          modelCnt [32];
    bit          modelOvf;

    always #5 clk = ~clk;

    register_file #(.NREG(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
        .Busy1D(Busy1D), .Busy2D(Busy2D),
        .RegWriteW(RegWriteW), .A3W(A3W), .WD3W(WD3W),
        .IssueD(IssueD), .RdD(RdD), .KillE(KillE), .RdE(RdE),
        .OvfErr(OvfErr)
    );

    function automatic logic [31:0] expRd(input int a);
        if (a == 0) return 32'h0;
        if (RegWriteW && int'(A3W) == a) return WD3W;
        return modelReg[a];
    endfunction

    function automatic logic expBusy(input int a);
        int pending;
        if (!rst || a == 0) return 1'b0;
        pending = modelCnt[a] - ((RegWriteW && int'(A3W) == a) ? 1 : 0);
        return pending != 0;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            modelReg[r] = 32'h0;
            modelCnt[r] = 0;
        end
        modelOvf = 1'b0;
    endtask

    task automatic idle();
        A1D = 5'd0; A2D = 5'd0; A3W = 5'd0; RdD = 5'd0; RdE = 5'd0;
        WD3W = 32'h0; RegWriteW = 1'b0; IssueD = 1'b0; KillE = 1'b0;
    endtask

    // Advance one rising edge, update the model, return on the falling edge.
    task automatic clockEdge();
        @(posedge clk);
        $display("edge t=%0t rst=%b we=%b a3=%0d wd=%h iss=%b rd=%0d kill=%b rde=%0d",
                 $time, rst, RegWriteW, A3W, WD3W, IssueD, RdD, KillE, RdE);
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                int n;
                n = modelCnt[r] + ((IssueD && int'(RdD) == r) ? 1 : 0)
                                - ((RegWriteW && int'(A3W) == r) ? 1 : 0)
                                - ((KillE && int'(RdE) == r) ? 1 : 0);
                if (n > 3) begin
                    n = 3; modelOvf = 1'b1;
                end else if (n < 0) begin
                    n = 0; modelOvf = 1'b1;
                end
                modelCnt[r] = n;
            end
            if (RegWriteW && A3W != 5'd0) modelReg[A3W] = WD3W;
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [4:0] r, input int times);
        for (int i = 0; i < times; i++) begin
            idle(); IssueD = 1'b1; RdD = r; #1; clockEdge();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; idle(); modelReset(); A1D = 5'd5; A2D = 5'd9;
        #1;
        nVec++; if (RD1D !== 32'h0) begin nErr++; $display("FAIL reset_rd1 got %h expected 0", RD1D); end
        nVec++; if (Busy1D !== 1'b0) begin nErr++; $display("FAIL reset_busy1 got %b expected 0", Busy1D); end
        nVec++; if (OvfErr !== 1'b0) begin nErr++; $display("FAIL reset_ovf got %b expected 0", OvfErr); end
        clockEdge(); clockEdge();
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        issue(5'd5, 1);
        idle(); RegWriteW = 1'b1; A3W = 5'd5; WD3W = 32'hDEADBEEF; #1; clockEdge();
        idle(); A1D = 5'd5; A2D = 5'd5; #1;
        nVec++; if (RD1D !== 32'hDEADBEEF) begin nErr++; $display("FAIL wr_rd1 got %h expected deadbeef", RD1D); end
        nVec++; if (RD2D !== 32'hDEADBEEF) begin nErr++; $display("FAIL wr_rd2 got %h expected deadbeef", RD2D); end
        nVec++; if (Busy1D !== expBusy(5)) begin nErr++; $display("FAIL wr_busy1 got %b expected %b", Busy1D, expBusy(5)); end
        clockEdge();
        idle(); A1D = 5'd0; RegWriteW = 1'b1; A3W = 5'd0; WD3W = 32'h1234; #1;
        nVec++; if (RD1D !== 32'h0) begin nErr++; $display("FAIL x0_bypass got %h expected 0", RD1D); end
        clockEdge();
        idle(); A1D = 5'd0; #1;
        nVec++; if (RD1D !== 32'h0) begin nErr++; $display("FAIL x0_read got %h expected 0", RD1D); end
        nVec++; if (OvfErr !== 1'b0) begin nErr++; $display("FAIL wr_ovf got %b expected 0", OvfErr); end
    endtask

    task automatic test_bypass();
        issue(5'd7, 2);
        idle(); RegWriteW = 1'b1; A3W = 5'd7; WD3W = 32'h11; #1; clockEdge();
        idle(); RegWriteW = 1'b1; A3W = 5'd7; WD3W = 32'h22; A1D = 5'd7; #1;
        nVec++; if (RD1D !== 32'h22) begin nErr++; $display("FAIL bypass_rd1 got %h expected 22", RD1D); end
        nVec++; if (Busy1D !== 1'b0) begin nErr++; $display("FAIL bypass_busy got %b expected 0", Busy1D); end
        clockEdge();
        idle(); A1D = 5'd7; #1;
        nVec++; if (RD1D !== 32'h22) begin nErr++; $display("FAIL stored_rd1 got %h expected 22", RD1D); end
    endtask

    task automatic test_scoreboard();
        logic expSeq [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            idle(); IssueD = 1'b1; RdD = 5'd3; A1D = 5'd3; #1;
            nVec++; if (Busy1D !== expBusy(3)) begin nErr++; $display("FAIL sb_issue%0d got %b expected %b", i, Busy1D, expBusy(3)); end
            clockEdge();
        end
        for (int i = 0; i < 3; i++) begin
            idle(); RegWriteW = 1'b1; A3W = 5'd3; WD3W = $urandom; A1D = 5'd3; A2D = 5'd3; #1;
            nVec++; if (Busy1D !== expSeq[i]) begin nErr++; $display("FAIL sb_wb%0d got %b expected %b", i, Busy1D, expSeq[i]); end
            nVec++; if (RD2D !== expRd(3)) begin nErr++; $display("FAIL sb_rd2_%0d got %h expected %h", i, RD2D, expRd(3)); end
            clockEdge();
        end
        idle(); A1D = 5'd3; #1;
        nVec++; if (Busy1D !== 1'b0) begin nErr++; $display("FAIL sb_drained got %b expected 0", Busy1D); end
        nVec++; if (OvfErr !== 1'b0) begin nErr++; $display("FAIL sb_ovf got %b expected 0", OvfErr); end
    endtask

    task automatic test_triple_event();
        issue(5'd9, 2);
        idle(); IssueD = 1'b1; RdD = 5'd9; RegWriteW = 1'b1; A3W = 5'd9;
        WD3W = 32'h99; KillE = 1'b1; RdE = 5'd9; #1; clockEdge();
        idle(); A2D = 5'd9; #1;
        nVec++; if (Busy2D !== 1'b1) begin nErr++; $display("FAIL tri_busy got %b expected 1", Busy2D); end
        clockEdge();
        // A single completing writer must clear busy if exactly one remains.
        idle(); RegWriteW = 1'b1; A3W = 5'd9; WD3W = 32'h9A; A2D = 5'd9; #1;
        nVec++; if (Busy2D !== 1'b0) begin nErr++; $display("FAIL tri_last got %b expected 0", Busy2D); end
        clockEdge();
        idle(); A2D = 5'd9; #1;
        nVec++; if (Busy2D !== 1'b0) begin nErr++; $display("FAIL tri_done got %b expected 0", Busy2D); end
        nVec++; if (OvfErr !== 1'b0) begin nErr++; $display("FAIL tri_ovf got %b expected 0", OvfErr); end
    endtask

    task automatic test_saturation();
        logic expSeq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        issue(5'd4, 4);
        idle(); A1D = 5'd4; #1;
        nVec++; if (OvfErr !== 1'b1) begin nErr++; $display("FAIL sat_ovf got %b expected 1", OvfErr); end
        nVec++; if (Busy1D !== 1'b1) begin nErr++; $display("FAIL sat_busy got %b expected 1", Busy1D); end
        // Held at 3: the third completion drains it, the fourth underflows.
        for (int i = 0; i < 4; i++) begin
            idle(); RegWriteW = 1'b1; A3W = 5'd4; WD3W = 32'h40 + 32'(i); A1D = 5'd4; #1;
            nVec++; if (Busy1D !== expSeq[i]) begin nErr++; $display("FAIL sat_wb%0d got %b expected %b", i, Busy1D, expSeq[i]); end
            clockEdge();
        end
        idle(); A1D = 5'd4; #1;
        nVec++; if (Busy1D !== 1'b0) begin nErr++; $display("FAIL sat_floor got %b expected 0", Busy1D); end
        nVec++; if (OvfErr !== 1'b1) begin nErr++; $display("FAIL sat_sticky got %b expected 1", OvfErr); end
    endtask

    task automatic test_async_reset();
        issue(5'd5, 3);
        idle(); RegWriteW = 1'b1; A3W = 5'd5; WD3W = 32'hAA; #1; clockEdge();
        idle(); A1D = 5'd5; A2D = 5'd5; #1;
        nVec++; if (RD1D !== 32'hAA) begin nErr++; $display("FAIL pre_rst_rd got %h expected aa", RD1D); end
        nVec++; if (Busy1D !== 1'b1) begin nErr++; $display("FAIL pre_rst_busy got %b expected 1", Busy1D); end
        #2 rst = 1'b0; modelReset();
        #1;
        nVec++; if (RD1D !== 32'h0) begin nErr++; $display("FAIL async_rd1 got %h expected 0", RD1D); end
        nVec++; if (Busy2D !== 1'b0) begin nErr++; $display("FAIL async_busy2 got %b expected 0", Busy2D); end
        nVec++; if (OvfErr !== 1'b0) begin nErr++; $display("FAIL async_ovf got %b expected 0", OvfErr); end
        clockEdge();
        rst = 1'b1; #1;
        nVec++; if (RD2D !== 32'h0) begin nErr++; $display("FAIL post_rst_rd2 got %h expected 0", RD2D); end
        nVec++; if (Busy1D !== 1'b0) begin nErr++; $display("FAIL post_rst_busy1 got %b expected 0", Busy1D); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idle();
            A1D = 5'($urandom_range(0, 7));
            A2D = 5'($urandom_range(0, 7));
            IssueD = 1'($urandom_range(0, 1));
            RdD = 5'($urandom_range(0, 7));
            RegWriteW = 1'($urandom_range(0, 1));
            A3W = 5'($urandom_range(0, 7));
            WD3W = $urandom;
            KillE = ($urandom_range(0, 3) == 0);
            RdE = 5'($urandom_range(0, 7));
            #1;
            nVec++; if (RD1D !== expRd(int'(A1D))) begin nErr++; $display("FAIL rnd%0d_rd1 got %h expected %h", i, RD1D, expRd(int'(A1D))); end
            nVec++; if (RD2D !== expRd(int'(A2D))) begin nErr++; $display("FAIL rnd%0d_rd2 got %h expected %h", i, RD2D, expRd(int'(A2D))); end
            nVec++; if (Busy1D !== expBusy(int'(A1D))) begin nErr++; $display("FAIL rnd%0d_busy1 got %b expected %b", i, Busy1D, expBusy(int'(A1D))); end
            nVec++; if (Busy2D !== expBusy(int'(A2D))) begin nErr++; $display("FAIL rnd%0d_busy2 got %b expected %b", i, Busy2D, expBusy(int'(A2D))); end
            nVec++; if (OvfErr !== modelOvf) begin nErr++; $display("FAIL rnd%0d_ovf got %b expected %b", i, OvfErr, modelOvf); end
            clockEdge();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_triple_event();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
